// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default widths/sizes and the bit-reversal used by
// the SDF stages and the output reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int DATA_IN_WIDTH = 16;
  localparam int FFT_LOG2N     = 6;

  // Reverses the low 'width' bits of 'value'; upper result bits are zero.
  function automatic logic [31:0] bitRev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[i] = value[width-1-i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_dpram.sv
// Simple dual-port RAM, one write and one registered read port, no reset,
// written so synthesis maps it onto block RAM.
module fft_bitrev_reorder_dpram #(
  parameter int AW = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage: buffers bit-reversed SDF frames in a ping-pong RAM
// and replays each one in natural bin order as a contiguous burst.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = DATA_IN_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             di_en,
  input  logic [DW-1:0]    di_re,
  input  logic [DW-1:0]    di_im,
  output logic             do_en,
  output logic [DW-1:0]    do_re,
  output logic [DW-1:0]    do_im,
  output logic [LOG2N-1:0] do_idx,
  output logic             do_last
);

  localparam int AW = LOG2N + 1;
  localparam logic [LOG2N-1:0] LastIdx = '1;
  localparam logic [LOG2N-1:0] OneIdx  = LOG2N'(1);

  logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             wbank_q, wbank_d, rbank_q, rbank_d, rd_act_q, rd_act_d;
  logic             do_en_q, do_last_q, seen_q;
  logic [LOG2N-1:0] do_idx_q;
  logic             frameDone;
  logic [AW-1:0]    waddr, raddr;
  logic [2*DW-1:0]  rdata;

  always_comb begin
    frameDone = di_en && (wcnt_q == LastIdx);
    waddr     = {wbank_q, LOG2N'(bitRev(32'(wcnt_q), LOG2N))};
    raddr     = {rbank_q, rcnt_q};
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    rd_act_d  = rd_act_q;
    rcnt_d    = rcnt_q;
    if (di_en) begin
      wcnt_d = wcnt_q + OneIdx;
    end
    if (rd_act_q) begin
      rcnt_d = rcnt_q + OneIdx;
      if (rcnt_q == LastIdx) begin
        rd_act_d = 1'b0;
      end
    end
    // A completing frame wins over the end of the current burst, giving back-to-back output.
    if (frameDone) begin
      wbank_d  = ~wbank_q;
      rbank_d  = wbank_q;
      rd_act_d = 1'b1;
      rcnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      rd_act_q  <= 1'b0;
      rcnt_q    <= '0;
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_idx_q  <= '0;
      seen_q    <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      rd_act_q  <= rd_act_d;
      rcnt_q    <= rcnt_d;
      do_en_q   <= rd_act_q;
      do_last_q <= rd_act_q && (rcnt_q == LastIdx);
      if (rd_act_q) begin
        do_idx_q <= rcnt_q;
        seen_q   <= 1'b1;
      end
    end
  end

  fft_bitrev_reorder_dpram #(
    .AW   (AW),
    .WIDTH(2*DW)
  ) u_ram (
    .clk    (clk),
    .we_i   (di_en),
    .waddr_i(waddr),
    .wdata_i({di_re, di_im}),
    .re_i   (rd_act_q),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  // The RAM read register has no reset, so outputs read as zero until the first read after reset.
  assign do_en   = do_en_q;
  assign do_last = do_last_q;
  assign do_idx  = do_idx_q;
  assign do_re   = seen_q ? rdata[2*DW-1:DW] : '0;
  assign do_im   = seen_q ? rdata[DW-1:0]    : '0;

  noOverflow: assert property (@(posedge clk) disable iff (!rstn)
    !(frameDone && rd_act_q && (rcnt_q != LastIdx)));

endmodule
